uart_tx_drain: RTL and testbench

Read-side controller for the UART loop's 8-entry 1r1w byte RAM. It watches the receive-side write pointer and fetches each pending byte through the RAM's registered read port. Each byte is serialized on the TX pin as 8N1, LSB first. It returns its read pointer so the receive side can detect buffer-full.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_drain_if.sv | 13 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_drain.sv | 81 ++++++++
 tb/tb_uart_tx_drain.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the TX drain and RX side
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int RAM_AW           = 3;
  localparam int PTR_W            = RAM_AW + 1;
  localparam int BAUD_DIV_DEFAULT = 208;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Pointers carry a wrap bit above the slot index, so equality alone means empty.
  function automatic logic ptr_empty(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
    return wr == rd;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// rtl/uart_tx_drain_if.sv - pointer exchange and RAM read port between the writer/RAM and the drain
interface uart_tx_drain_if;
  import uart_pkg::*;

  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [RAM_AW-1:0]         ram_radr;
  logic [UART_DATA_BITS-1:0] ram_rdata;

  modport master (input wr_ptr, input ram_rdata, output rd_ptr, output ram_radr);
  modport slave  (output wr_ptr, output ram_rdata, input rd_ptr, input ram_radr);

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - BAUD_DIV cycle counter with synchronous clear and a one-cycle tick on the last count
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - drains the UART loop byte RAM and serializes each byte as 8N1, LSB first
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  uart_tx_drain_if.master  bus,
  output logic             uart_tx,
  output logic             tx_busy
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);

  tx_state_e                 state;
  tx_state_e                 state_next;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]          bit_idx;
  logic                      baud_tick;
  logic                      baud_clr;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (baud_tick)
  );

  always_comb begin
    state_next = state;
    uart_tx    = 1'b1;
    unique case (state)
      IDLE:  if (tx_en && !ptr_empty(bus.wr_ptr, rd_ptr_q)) state_next = FETCH;
      FETCH: state_next = START;
      START: begin
        uart_tx = 1'b0;
        if (baud_tick) state_next = DATA;
      end
      DATA: begin
        uart_tx = shift_reg[0];
        if (baud_tick && bit_idx == IDX_W'(UART_DATA_BITS - 1)) state_next = STOP;
      end
      STOP:  if (baud_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Every bit period starts from count 0, including the first one after FETCH.
    baud_clr = (state_next != state) || (state == IDLE) || (state == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr_q  <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      state <= state_next;
      case (state)
        // The RAM registered this slot on the previous edge; release it as soon as it is captured.
        FETCH: begin
          shift_reg <= bus.ram_rdata;
          rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        end
        START: if (baud_tick) bit_idx <= '0;
        DATA: if (baud_tick) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign tx_busy      = (state != IDLE);
  assign bus.rd_ptr   = rd_ptr_q;
  assign bus.ram_radr = rd_ptr_q[RAM_AW-1:0];

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - directed vector bench for uart_tx_drain with a registered-read RAM and writer model
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
  localparam int MID   = 1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    logic [3:0] rd;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       uart_tx;
  logic       tx_busy;
  logic       we    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] mem [8];
  int         cyc     = 0;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  vec_t       tbl [8];
  logic [7:0] rx_d;
  int         rx_t;
  bit         rx_ok;
  int         prev_t;
  int         tf;

  uart_tx_drain_if bus ();

  uart_tx_drain #(.BAUD_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_en   (tx_en),
    .bus     (bus),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Writer bumps wr_ptr on the same edge that writes the slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.wr_ptr <= 4'd0;
    else if (we) bus.wr_ptr <= bus.wr_ptr + 4'd1;
  end

  always @(posedge clk) begin
    if (we) mem[bus.wr_ptr[2:0]] <= wdata;
    bus.ram_rdata <= mem[bus.ram_radr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    we    = 1'b1;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    we    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge right after the stop bit.
  task automatic rx_byte(output logic [7:0] d, output int t_fall, output bit ok);
    int n = 0;
    d = 8'h00;
    ok = 1'b1;
    t_fall = 0;
    while (uart_tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t_fall = cyc;
    repeat (DIV + MID) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      d[b] = uart_tx;
      repeat (DIV) @(negedge clk);
    end
    if (uart_tx !== 1'b1) ok = 1'b0;
    repeat (DIV - MID) @(negedge clk);
  endtask

  task automatic watch_idle(input string name, input int n);
    int lows = 0;
    int busys = 0;
    for (int i = 0; i < n; i++) begin
      if (uart_tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
      @(negedge clk);
    end
    check({name, "_line_low_cycles"}, 32'(lows), 0);
    check({name, "_busy_cycles"}, 32'(busys), 0);
  endtask

  initial begin
    tbl[0] = '{8'h55, 10'h2AA, 4'd1};
    tbl[1] = '{8'h00, 10'h200, 4'd2};
    tbl[2] = '{8'hFF, 10'h3FE, 4'd3};
    tbl[3] = '{8'h01, 10'h202, 4'd4};
    tbl[4] = '{8'h80, 10'h300, 4'd5};
    tbl[5] = '{8'h3C, 10'h278, 4'd6};
    tbl[6] = '{8'hC6, 10'h38C, 4'd7};
    tbl[7] = '{8'hA3, 10'h346, 4'd8};

    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 1);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_rd_ptr", 32'(bus.rd_ptr), 0);
    check("rst_ram_radr", 32'(bus.ram_radr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full buffer: slots equal, wrap bits differ.
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'hF0 + 8'(i));
    repeat (4) @(negedge clk);
    check("full_held_busy", 32'(tx_busy), 0);
    check("full_held_rd_ptr", 32'(bus.rd_ptr), 0);
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_byte(rx_d, rx_t, rx_ok);
      check("full_frame_ok", 32'(rx_ok), 1);
      check("full_data", 32'(rx_d), 32'(8'hF0 + 8'(i)));
    end
    check("full_rd_ptr_end", 32'(bus.rd_ptr), 8);
    watch_idle("full_after", 60);

    // Table: one byte per vector, exact cycle timing; slot 7 holds stale 0xF7 before 0xA3 lands.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [9:0] cap;
      int glitches;
      int e0;
      cap = 10'h000;
      glitches = 0;
      we = 1'b1;
      wdata = tbl[i].data;
      @(negedge clk);
      we = 1'b0;
      e0 = cyc;
      check("vec_e0_busy", 32'(tx_busy), 0);
      @(negedge clk);
      check("vec_e1_busy", 32'(tx_busy), 1);
      check("vec_e1_line", 32'(uart_tx), 1);
      check("vec_e1_rd_ptr", 32'(bus.rd_ptr), 32'(4'(tbl[i].rd - 4'd1)));
      @(negedge clk);
      check("vec_e2_rd_ptr", 32'(bus.rd_ptr), 32'(tbl[i].rd));
      for (int c = 0; c < FRAME; c++) begin
        if (c % DIV == MID) cap[c / DIV] = uart_tx;
        if (uart_tx !== tbl[i].line[c / DIV]) glitches++;
        if (c == FRAME - 1) check("vec_busy_last_stop", 32'(tx_busy), 1);
        @(negedge clk);
      end
      check("vec_frame", 32'(cap), 32'(tbl[i].line));
      check("vec_bit_timing", 32'(glitches), 0);
      check("vec_busy_after", 32'(tx_busy), 0);
      check("vec_idle_line", 32'(uart_tx), 1);
      if (cyc - e0 != FRAME + 2) check("vec_elapsed", 32'(cyc - e0), FRAME + 2);
    end

    // Burst of 10 with wrap, writer fills as space allows.
    do_reset();
    tx_en = 1'b1;
    prev_t = 0;
    fork
      begin : wr_proc
        int k;
        int n;
        k = 0;
        n = 0;
        while (k < 10 && n < 2000) begin
          if ((bus.wr_ptr ^ bus.rd_ptr) != 4'b1000) begin
            we = 1'b1;
            wdata = 8'(k);
            k++;
          end else begin
            we = 1'b0;
          end
          @(negedge clk);
          n++;
        end
        we = 1'b0;
      end
      begin : rx_proc
        for (int i = 0; i < 10; i++) begin
          rx_byte(rx_d, rx_t, rx_ok);
          check("burst_frame_ok", 32'(rx_ok), 1);
          check("burst_data", 32'(rx_d), 32'(i));
          if (i > 0) check("burst_gap", 32'(rx_t - prev_t), FRAME + 2);
          prev_t = rx_t;
        end
      end
    join
    check("burst_rd_ptr_end", 32'(bus.rd_ptr), 10);

    // tx_en gating mid-frame with 3 bytes pending.
    do_reset();
    tx_en = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    tx_en = 1'b1;
    fork
      begin
        rx_byte(rx_d, rx_t, rx_ok);
      end
      begin
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    check("gate_frame_ok", 32'(rx_ok), 1);
    check("gate_data0", 32'(rx_d), 32'h11);
    watch_idle("gate_hold", 60);
    check("gate_rd_ptr_held", 32'(bus.rd_ptr), 1);
    tx_en = 1'b1;
    @(negedge clk);
    check("gate_resume_fetch_line", 32'(uart_tx), 1);
    @(negedge clk);
    check("gate_resume_start", 32'(uart_tx), 0);
    rx_byte(rx_d, rx_t, rx_ok);
    check("gate_data1", 32'(rx_d), 32'h22);
    rx_byte(rx_d, rx_t, rx_ok);
    check("gate_data2", 32'(rx_d), 32'h33);
    check("gate_rd_ptr_end", 32'(bus.rd_ptr), 3);

    // Reset during DATA bit 3 of 0x55 (bit 3 is 0, so the line is low when reset hits).
    do_reset();
    tx_en = 1'b1;
    push(8'h55);
    tf = 0;
    while (uart_tx !== 1'b0 && tf < 20) begin
      @(negedge clk);
      tf++;
    end
    check("rstmid_start_seen", 32'(uart_tx), 0);
    repeat (4 * DIV + MID) @(negedge clk);
    check("rstmid_line_before", 32'(uart_tx), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_line", 32'(uart_tx), 1);
    check("rstmid_busy", 32'(tx_busy), 0);
    check("rstmid_rd_ptr", 32'(bus.rd_ptr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    watch_idle("rstmid_after", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
